eab_burst_agu: RTL and testbench
================================

Name: eab_burst_agu

Overview:
- Parametrised, registered successor to the combinational LC-3 effective-address adder.
- Computes `base + sext(IR offset field)`, with base selected from PC or Ra and one of three offset-field widths (or zero).
- Can emit a burst of consecutive addresses (base+off, +STRIDE, +2·STRIDE, …) from one request.
- Sits between decode/control and the memory-access sequencer; uses valid/ready handshakes on both sides.

Parameters:
- W, 16, address/data width of PC, Ra and ea.
- IR_W, 11, width of the ir input slice.
- OFF_A_W, 6, width of offset field A (`ir[OFF_A_W-1:0]`).
- OFF_B_W, 9, width of offset field B (`ir[OFF_B_W-1:0]`).
- OFF_C_W, 11, width of offset field C (`ir[OFF_C_W-1:0]`). All OFF_x_W ≤ IR_W ≤ W.
- MAX_BEATS, 8, maximum beats per burst (≥1).
- STRIDE, 1, unsigned increment between beats.
- BL_W, `$clog2(MAX_BEATS)` (min 1), width of beats_m1 and ea_idx; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ir  in  IR_W  instruction offset bits
- ra  in  W  register base
- pc  in  W  PC base
- sel_base  in  1  0 = pc, 1 = ra
- sel_off  in  2  00 = zero, 01 = field A, 10 = field B, 11 = field C (each sign-extended to W)
- beats_m1  in  BL_W  burst length minus one
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- ea_valid  out  1  ea beat valid
- ea_ready  in  1  consumer accepts beat when ea_valid && ea_ready
- ea  out  W  effective address of current beat
- ea_idx  out  BL_W  beat index within the burst (0-based)
- ea_last  out  1  current beat is the final beat of the burst
- ea_wrap  out  1  current beat's address wrapped past 2^W relative to the previous beat

Behaviour:
- **Reset:** asynchronous, active-low.
  - While rst_n is low: state=IDLE, ea_valid=0, ea=0, ea_idx=0, ea_last=0, ea_wrap=0, and req_ready is forced to 0.
  - Reset mid-burst abandons the burst; no beat is produced after release until a new request is accepted.
- **FSM states:** IDLE and BURST.
- **Request ready:** `req_ready = (state==IDLE) && (!ea_valid || ea_ready)`, combinational.
- **Acceptance:**
  - ir, ra, pc, sel_base, sel_off and beats_m1 are sampled only on the acceptance cycle and ignored otherwise.
  - beats_m1 values > MAX_BEATS-1 saturate to MAX_BEATS-1.
- **Latency:** registered. On the edge after acceptance: ea = base + sext(off) mod 2^W, ea_idx=0, ea_wrap=0, ea_valid=1, and ea_last = (len_m1==0).
  - Next state is BURST if len_m1 ≠ 0, else IDLE.
- **Arithmetic:** all sums are modulo 2^W.
  - Sign extension replicates the field MSB.
  - sel_off=00 gives offset 0.
- **Advancing in BURST:** on each ea handshake, the next beat is loaded:
  - ea ← ea + STRIDE
  - ea_idx ← ea_idx + 1
  - ea_wrap ← carry-out of that add
  - ea_last ← (ea_idx+1 == len_m1)
  - When the beat being loaded is the last one, state → IDLE.
- **Stall:** while ea_valid && !ea_ready, ea/ea_idx/ea_last/ea_wrap hold stable. No beat is dropped or duplicated.
- **Back-to-back requests:** in IDLE, a handshake of the last beat clears ea_valid unless a new request is accepted in the same cycle. In that case the new burst's beat 0 loads directly, with ea_valid staying high (zero bubble).
- **No overlap:** req_ready is 0 throughout BURST, so requests never overlap.

Test Plan:
1. **Single beat, field B:** pc=0x3000, sel_base=0, sel_off=10, ir[8:0]=0x1FF, beats_m1=0.
   - Required: one cycle after acceptance, ea=0x2FFF, ea_idx=0, ea_last=1, ea_wrap=0. State returns to IDLE; req_ready=1 after the handshake.
2. **Four-beat burst, field A:** ra=0x4000, sel_base=1, sel_off=01, ir[5:0]=0x05, beats_m1=3, ea_ready held high.
   - Required: ea = 0x4005, 0x4006, 0x4007, 0x4008 on consecutive cycles, with ea_idx 0..3 and ea_last only on 0x4008.
   - req_ready=0 until the last beat is loaded.
3. **Backpressure:** same as scenario 2, but ea_ready is deasserted for 3 cycles while ea=0x4006.
   - Required: ea/ea_idx hold at 0x4006/1 throughout the stall; the sequence then resumes with exactly 4 beats total.
4. **Wrap-around:** ra=0xFFFE, sel_base=1, sel_off=00, beats_m1=3.
   - Required: ea = 0xFFFE, 0xFFFF, 0x0000 (ea_wrap=1), 0x0001 (ea_wrap=0).
5. **Field C and back-to-back:** first request pc=0x0800, sel_off=11, ir[10:0]=0x400, beats_m1=0 gives ea=0x0400.
   - Hold a second request (beats_m1=1) valid while that beat handshakes.
   - Required: second request accepted the same cycle; ea_valid stays 1 with no idle cycle.
6. **Reset mid-burst:** rst_n driven low during beat idx 2 of a 4-beat burst.
   - Required: ea_valid=0, ea=0 and req_ready=0 immediately (asynchronous).
   - After release, req_ready=1 and the next request starts at ea_idx=0.

Source files
------------

// File: rtl/eab_burst_agu.sv
// Registered effective-address generator: base + sign-extended IR offset, optionally
// expanded into a burst of STRIDE-spaced addresses behind valid/ready handshakes.
module eab_burst_agu #(
    parameter int unsigned W         = 16,
    parameter int unsigned IR_W      = 11,
    parameter int unsigned OFF_A_W   = 6,
    parameter int unsigned OFF_B_W   = 9,
    parameter int unsigned OFF_C_W   = 11,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned STRIDE    = 1,
    localparam int unsigned BL_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IR_W-1:0] ir,
    input  logic [W-1:0]    ra,
    input  logic [W-1:0]    pc,
    input  logic            sel_base,
    input  logic [1:0]      sel_off,
    input  logic [BL_W-1:0] beats_m1,
    input  logic            req_valid,
    output logic            req_ready,
    output logic            ea_valid,
    input  logic            ea_ready,
    output logic [W-1:0]    ea,
    output logic [BL_W-1:0] ea_idx,
    output logic            ea_last,
    output logic            ea_wrap
);

    typedef enum logic [0:0] {StIdle, StBurst} stateT;

    localparam logic [BL_W-1:0] LenMax = BL_W'(MAX_BEATS - 1);

    stateT           stateQ;
    logic [BL_W-1:0] lenM1Q;

    logic [W-1:0]    baseSel;
    logic [W-1:0]    offSel;
    logic [W-1:0]    startEa;
    logic [BL_W-1:0] lenSat;
    logic [BL_W-1:0] nextIdx;
    logic [W:0]      stepSum;
    logic            reqFire;
    logic            eaFire;

    always_comb begin
        baseSel = sel_base ? ra : pc;
        unique case (sel_off)
            2'b01:   offSel = W'($signed(ir[OFF_A_W-1:0]));
            2'b10:   offSel = W'($signed(ir[OFF_B_W-1:0]));
            2'b11:   offSel = W'($signed(ir[OFF_C_W-1:0]));
            default: offSel = '0;
        endcase
        startEa = baseSel + offSel;
    end

    // Saturation is only needed when MAX_BEATS does not fill the beats_m1 range.
    if (MAX_BEATS == (1 << BL_W)) begin : gNoSat
        assign lenSat = beats_m1;
    end else begin : gSat
        assign lenSat = (beats_m1 > LenMax) ? LenMax : beats_m1;
    end

    // The carry bit of the stride add flags an address wrap past 2^W.
    assign stepSum = {1'b0, ea} + (W + 1)'(STRIDE);
    assign nextIdx = ea_idx + BL_W'(1);

    assign req_ready = rst_n && (stateQ == StIdle) && (!ea_valid || ea_ready);
    assign reqFire   = req_valid && req_ready;
    assign eaFire    = ea_valid && ea_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            lenM1Q   <= '0;
            ea_valid <= 1'b0;
            ea       <= '0;
            ea_idx   <= '0;
            ea_last  <= 1'b0;
            ea_wrap  <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    // A new request may replace a draining final beat with no bubble.
                    if (reqFire) begin
                        lenM1Q   <= lenSat;
                        ea_valid <= 1'b1;
                        ea       <= startEa;
                        ea_idx   <= '0;
                        ea_last  <= (lenSat == '0);
                        ea_wrap  <= 1'b0;
                        stateQ   <= (lenSat != '0) ? StBurst : StIdle;
                    end else if (eaFire) begin
                        ea_valid <= 1'b0;
                    end
                end
                StBurst: begin
                    if (eaFire) begin
                        ea      <= stepSum[W-1:0];
                        ea_wrap <= stepSum[W];
                        ea_idx  <= nextIdx;
                        ea_last <= (nextIdx == lenM1Q);
                        if (nextIdx == lenM1Q) begin
                            stateQ <= StIdle;
                        end
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_eab_burst_agu.sv
// Directed bench for eab_burst_agu: single beat, bursts, stall, wrap, back-to-back, reset.
module tb_eab_burst_agu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] ir;
    logic [15:0] ra;
    logic [15:0] pc;
    logic        sel_base;
    logic [1:0]  sel_off;
    logic [2:0]  beats_m1;
    logic        req_valid;
    logic        req_ready;
    logic        ea_valid;
    logic        ea_ready;
    logic [15:0] ea;
    logic [2:0]  ea_idx;
    logic        ea_last;
    logic        ea_wrap;

    int checkCnt = 0;
    int errCnt   = 0;

    eab_burst_agu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .ra        (ra),
        .pc        (pc),
        .sel_base  (sel_base),
        .sel_off   (sel_off),
        .beats_m1  (beats_m1),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ea_valid  (ea_valid),
        .ea_ready  (ea_ready),
        .ea        (ea),
        .ea_idx    (ea_idx),
        .ea_last   (ea_last),
        .ea_wrap   (ea_wrap)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input int addr, input int idx, input bit last,
                             input bit wrap);
        checkVal({tag, "_valid"}, 32'(ea_valid), 32'd1);
        checkVal({tag, "_ea"}, 32'(ea), 32'(addr));
        checkVal({tag, "_idx"}, 32'(ea_idx), 32'(idx));
        checkVal({tag, "_last"}, 32'(ea_last), 32'(last));
        checkVal({tag, "_wrap"}, 32'(ea_wrap), 32'(wrap));
    endtask

    // Called at a negedge; returns at the negedge where beat 0 is visible.
    task automatic reqStart(input bit sb, input logic [1:0] so, input logic [10:0] irv,
                            input logic [15:0] rav, input logic [15:0] pcv,
                            input logic [2:0] bm1);
        int n = 0;
        sel_base  = sb;
        sel_off   = so;
        ir        = irv;
        ra        = rav;
        pc        = pcv;
        beats_m1  = bm1;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        ir        = '0;
        ra        = 16'hDEAD;
        pc        = 16'hBEEF;
        beats_m1  = 3'd7;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ir        = '0;
        ra        = '0;
        pc        = '0;
        sel_base  = 1'b0;
        sel_off   = 2'b00;
        beats_m1  = '0;
        req_valid = 1'b0;
        ea_ready  = 1'b1;

        @(negedge clk);
        checkVal("rst_valid", 32'(ea_valid), 32'd0);
        checkVal("rst_ea", 32'(ea), 32'd0);
        checkVal("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkVal("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // 1: single beat, field B = -1
        reqStart(1'b0, 2'b10, 11'h1FF, 16'h0000, 16'h3000, 3'd0);
        checkBeat("t1", 'h2FFF, 0, 1'b1, 1'b0);
        checkVal("t1_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        checkVal("t1_drain", 32'(ea_valid), 32'd0);

        // 2: four-beat burst, field A
        reqStart(1'b1, 2'b01, 11'h005, 16'h4000, 16'h0000, 3'd3);
        for (int i = 0; i < 4; i++) begin
            checkBeat("t2", 'h4005 + i, i, i == 3, 1'b0);
            checkVal("t2_ready", 32'(req_ready), 32'(i == 3));
            @(negedge clk);
        end
        checkVal("t2_drain", 32'(ea_valid), 32'd0);

        // 3: backpressure on beat 1
        reqStart(1'b1, 2'b01, 11'h005, 16'h4000, 16'h0000, 3'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                ea_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checkBeat("t3_stall", 'h4006, 1, 1'b0, 1'b0);
                    @(negedge clk);
                end
                ea_ready = 1'b1;
            end
            checkBeat("t3", 'h4005 + i, i, i == 3, 1'b0);
            @(negedge clk);
        end
        checkVal("t3_drain", 32'(ea_valid), 32'd0);

        // 4: wrap-around
        reqStart(1'b1, 2'b00, 11'h7FF, 16'hFFFE, 16'h0000, 3'd3);
        checkBeat("t4_0", 'hFFFE, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkBeat("t4_1", 'hFFFF, 1, 1'b0, 1'b0);
        @(negedge clk);
        checkBeat("t4_2", 'h0000, 2, 1'b0, 1'b1);
        @(negedge clk);
        checkBeat("t4_3", 'h0001, 3, 1'b1, 1'b0);
        @(negedge clk);
        checkVal("t4_drain", 32'(ea_valid), 32'd0);

        // 5: field C then back-to-back request with no bubble
        reqStart(1'b0, 2'b11, 11'h400, 16'h0000, 16'h0800, 3'd0);
        checkBeat("t5_a", 'h0400, 0, 1'b1, 1'b0);
        sel_base  = 1'b1;
        sel_off   = 2'b00;
        ra        = 16'h1000;
        beats_m1  = 3'd1;
        req_valid = 1'b1;
        checkVal("t5_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkBeat("t5_b0", 'h1000, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkBeat("t5_b1", 'h1001, 1, 1'b1, 1'b0);
        @(negedge clk);
        checkVal("t5_drain", 32'(ea_valid), 32'd0);

        // 6: asynchronous reset during beat 2
        reqStart(1'b1, 2'b00, 11'h000, 16'h2000, 16'h0000, 3'd3);
        @(negedge clk);
        @(negedge clk);
        checkBeat("t6_pre", 'h2002, 2, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkVal("t6_rst_valid", 32'(ea_valid), 32'd0);
        checkVal("t6_rst_ea", 32'(ea), 32'd0);
        checkVal("t6_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("t6_rel_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkVal("t6_idle_valid", 32'(ea_valid), 32'd0);
        reqStart(1'b1, 2'b00, 11'h000, 16'h5000, 16'h0000, 3'd1);
        checkBeat("t6_new", 'h5000, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkBeat("t6_new1", 'h5001, 1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
